// File: rtl/mm_stream_reader.sv
// rtl/mm_stream_reader.sv - RAM-to-AXI4-Stream reader with 2-entry skid FIFO; READER_LOOP_EN adds multi-pass looping
module mm_stream_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
`ifdef READER_LOOP_EN
    input  logic              loop,
`endif
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic [DATA_W-1:0] buf_data_q [2];
    logic [DATA_W-1:0] buf_data_d [2];
    logic [1:0]        buf_last_q, buf_last_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              done_q, done_d;

    logic              loop_w;
    logic              push;
    logic              pop;
    logic              head_last;
    logic              issue;
    logic              last_issue;
    logic [ADDR_W-1:0] last_addr;
    logic [2:0]        occ;

`ifdef READER_LOOP_EN
    assign loop_w = loop;
`else
    assign loop_w = 1'b0;
`endif

    assign m_axis_tvalid = (count_q != 2'd0);
    assign m_axis_tdata  = buf_data_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid & buf_last_q[rd_ptr_q];
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign mem_en        = issue;
    assign mem_addr      = rd_addr_q;

    always_comb begin
        push      = inflight_q;
        pop       = m_axis_tvalid & m_axis_tready;
        head_last = buf_last_q[rd_ptr_q];
        // Slots that will be committed after this cycle: what survives the pop plus the word in flight.
        occ       = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
        last_addr = (state_q == ST_IDLE) ? (len - ONE) : (len_q - ONE);

        state_d         = state_q;
        len_d           = len_q;
        rd_addr_d       = rd_addr_q;
        done_d          = 1'b0;
        issue           = 1'b0;
        buf_data_d      = buf_data_q;
        buf_last_d      = buf_last_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        count_d         = count_q;

        case (state_q)
            ST_IDLE: begin
                // Address 0 is read in the accept cycle so the first beat lands two cycles later.
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        issue = 1'b1;
                        len_d = len;
                    end
                end
            end
            ST_RUN: begin
                issue = (occ < 3'd2);
            end
            ST_DRAIN: begin
                if (pop && head_last && (count_q == 2'd1) && !inflight_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        last_issue = issue && (rd_addr_q == last_addr);
        if (issue) begin
            if (last_issue) begin
                rd_addr_d = '0;
                state_d   = loop_w ? ST_RUN : ST_DRAIN;
            end else begin
                rd_addr_d = rd_addr_q + ONE;
                state_d   = ST_RUN;
            end
        end

        if (pop && head_last) begin
            done_d = 1'b1;
        end

        inflight_d      = issue;
        inflight_last_d = last_issue;

        if (push) begin
            buf_data_d[wr_ptr_q] = mem_rdata;
            buf_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= ST_IDLE;
            len_q           <= '0;
            rd_addr_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_data_q      <= '{default: '0};
            buf_last_q      <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= '0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            rd_addr_q       <= rd_addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            buf_data_q      <= buf_data_d;
            buf_last_q      <= buf_last_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            done_q          <= done_d;
        end
    end

endmodule

// File: tb/tb_mm_stream_reader.sv
// tb/tb_mm_stream_reader.sv - directed table-driven bench for mm_stream_reader
module tb_mm_stream_reader;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    typedef struct {
        int         n;
        logic [7:0] pat;
        int         exp_beats;
        int         exp_first;
        int         exp_done;
    } vec_t;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              start;
    logic [ADDR_W-1:0] len;
    logic              loop_i;
    logic              busy;
    logic              done;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    int total, bad, cyc;
    int beat_cnt, issue_cnt, done_cnt;
    int beat_base, issue_base, done_base;
    int cur_len, cur_dones, start_cyc, first_valid, done_rel;
    bit busy_seen, busy_gap, prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic prev_last;
    vec_t vecs[6];

    mm_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .len           (len),
`ifdef READER_LOOP_EN
        .loop          (loop_i),
`endif
        .busy          (busy),
        .done          (done),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 aclk = ~aclk;

    // RAM[i] = i + 0x100, one-cycle read latency
    always @(posedge aclk) begin
        if (mem_en) mem_rdata <= 32'h100 + {20'd0, mem_addr};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int mod_len(input int v);
        return (cur_len == 0) ? v : (v % cur_len);
    endfunction

    task automatic sample();
        int rel;
        if (aresetn) begin
            if (busy) busy_seen = 1'b1;
            if (done) begin
                done_cnt++;
                done_rel = cyc - start_cyc;
            end
            if (cur_len != 0 && (cyc - start_cyc) >= 1 && !busy && (done_cnt - done_base) < cur_dones)
                busy_gap = 1'b1;
            if (m_axis_tvalid && first_valid < 0) first_valid = cyc - start_cyc;
            if (prev_stall) begin
                chk("hold_tvalid", m_axis_tvalid, 1);
                chk("hold_tdata", m_axis_tdata, prev_data);
                chk("hold_tlast", m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                rel = mod_len(beat_cnt - beat_base);
                chk("tdata", m_axis_tdata, 32'h100 + rel);
                chk("tlast", m_axis_tlast, rel == cur_len - 1);
                beat_cnt++;
            end
            if (mem_en) begin
                rel = mod_len(issue_cnt - issue_base);
                chk("mem_addr", mem_addr, rel);
                issue_cnt++;
                chk("outstanding_le2", ((issue_cnt - issue_base) - (beat_cnt - beat_base)) <= 2, 1);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end else begin
            prev_stall = 1'b0;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge aclk);
        sample();
        @(posedge aclk);
        #1;
    endtask

    task automatic open_xfer(input int n, input int dones);
        beat_base   = beat_cnt;
        issue_base  = issue_cnt;
        done_base   = done_cnt;
        cur_len     = n;
        cur_dones   = dones;
        first_valid = -1;
        done_rel    = -1;
        busy_seen   = 1'b0;
        busy_gap    = 1'b0;
        start_cyc   = cyc;
    endtask

    task automatic run_vec(input string tag, input int n, input logic [7:0] pat, input int inj,
                           input int loop_off, input int exp_beats, input int exp_first,
                           input int exp_done, input int exp_dones);
        bit finished;
        open_xfer(n, exp_dones);
        len = n[ADDR_W-1:0];
        finished = 1'b0;
        for (int c = 0; c < 5000 && !finished; c++) begin
            start = (c == 0) || (c == inj);
            if (c == inj) len = 12'd9;
            if (c == loop_off) loop_i = 1'b0;
            m_axis_tready = pat[c % 8];
            step();
            if ((done_cnt - done_base) >= exp_dones) finished = 1'b1;
        end
        start = 1'b0;
        m_axis_tready = 1'b1;
        chk({tag, "_timeout"}, finished, 1);
        step();
        step();
        chk({tag, "_beats"}, beat_cnt - beat_base, exp_beats);
        chk({tag, "_dones"}, done_cnt - done_base, exp_dones);
        chk({tag, "_first_tvalid"}, first_valid, exp_first);
        chk({tag, "_done_cycle"}, done_rel, exp_done);
        chk({tag, "_busy_seen"}, busy_seen, n != 0);
        chk({tag, "_busy_gap"}, busy_gap, 0);
        chk({tag, "_end_busy"}, busy, 0);
        chk({tag, "_end_tvalid"}, m_axis_tvalid, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_tlast"}, m_axis_tlast, 0);
        chk({tag, "_tdata"}, m_axis_tdata, 0);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        beat_cnt = 0; issue_cnt = 0; done_cnt = 0;
        beat_base = 0; issue_base = 0; done_base = 0;
        cur_len = 0; cur_dones = 0; start_cyc = 0; first_valid = -1; done_rel = -1;
        busy_seen = 0; busy_gap = 0; prev_stall = 0; prev_data = '0; prev_last = 1'b0;
        aresetn = 1'b0; start = 1'b0; len = '0; m_axis_tready = 1'b1; loop_i = 1'b0;

        // {len, tready pattern (bit k = cycle k mod 8), beats, first tvalid, done cycle}
        vecs[0] = '{0,    8'hFF, 0,    -1, 1};
        vecs[1] = '{1,    8'hFF, 1,     2, 3};
        vecs[2] = '{4,    8'hFF, 4,     2, 6};
        vecs[3] = '{6,    8'h99, 6,     2, 13};
        vecs[4] = '{3,    8'h01, 3,     2, 25};
        vecs[5] = '{4095, 8'hFF, 4095,  2, 4097};

        #2;
        chk_zero("reset");
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].n, vecs[i].pat, -1, -1,
                    vecs[i].exp_beats, vecs[i].exp_first, vecs[i].exp_done,
                    (vecs[i].n == 0) ? 1 : 1);
        end

        run_vec("start_busy", 5, 8'hFF, 3, -1, 5, 2, 7, 1);

        open_xfer(8, 1);
        start = 1'b1; len = 12'd8; m_axis_tready = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("rst_mid_beats_before", beat_cnt - beat_base, 2);
        chk("rst_mid_tvalid_before", m_axis_tvalid, 1);
        aresetn = 1'b0;
        #1;
        chk_zero("rst_mid");
        step(); step();
        aresetn = 1'b1;
        step(); step(); step();
        chk("rst_mid_no_done", done_cnt - done_base, 0);
        chk("rst_mid_idle_tvalid", m_axis_tvalid, 0);

        run_vec("post_reset", 2, 8'hFF, -1, -1, 2, 2, 4, 1);

`ifdef READER_LOOP_EN
        loop_i = 1'b1;
        run_vec("loop", 3, 8'hFF, -1, 6, 9, 2, 11, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
